// File: rtl/mem_line_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_responder_if
//  Brief    : Cache-to-memory request bus. The cache drives the level
//             requests, the address and the write line. The responder
//             returns the read line, ready/done handshakes and the
//             protocol error flag.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_line_responder_if #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 26
);
  logic                         mem_w_line;
  logic                         mem_r_line;
  logic                         mem_w_one;
  logic                         mem_r_one;
  logic [ADDR_W-1:0]            mem_addr;
  logic [LINE_WORDS-1:0][31:0]  line_store;
  logic [LINE_WORDS-1:0][31:0]  line_read;
  logic                         mem_ready;
  logic                         mem_done;
  logic                         protocol_err;

  // Cache side
  modport master (
    output mem_w_line, mem_r_line, mem_w_one, mem_r_one, mem_addr, line_store,
    input  line_read, mem_ready, mem_done, protocol_err
  );

  // Memory responder side
  modport slave (
    input  mem_w_line, mem_r_line, mem_w_one, mem_r_one, mem_addr, line_store,
    output line_read, mem_ready, mem_done, protocol_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_responder
//  Brief    : Services whole-line and single-word read/write requests
//             against a single-port word-wide SRAM (one-cycle read latency).
//             A line is serialised into LINE_WORDS word accesses; completion
//             is signalled with a one-cycle mem_done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module mem_line_responder #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 26,
  parameter int SRAM_AW    = 16
) (
  input  logic               clk,
  input  logic               rst_l,
  mem_line_responder_if.slave bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic               sram_we,
  output logic               sram_re,
  input  logic [31:0]        sram_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  // One extra bit so the line read can spend a drain cycle at idx == LINE_WORDS
  localparam int IDX_W = OFF_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_LINE  = 3'd1,
    S_R_LINE  = 3'd2,
    S_W_ONE   = 3'd3,
    S_R_ONE   = 3'd4,
    S_DONE    = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [SRAM_AW-1:0]          addr_q, addr_d;
  logic [LINE_WORDS-1:0][31:0] store_q, store_d;
  logic [LINE_WORDS-1:0][31:0] line_read_q, line_read_d;
  logic                        rd_pend_q, rd_pend_d;
  logic [OFF_W-1:0]            rd_idx_q, rd_idx_d;
  logic                        perr_q, perr_d;

  logic       any_req;
  logic       multi_req;
  logic [2:0] req_count;

  // Request address bits above the SRAM range are intentionally dropped
  generate
    if (ADDR_W > SRAM_AW) begin : g_addr_hi_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:SRAM_AW];
    end
  endgenerate

  assign req_count = {2'b00, bus.mem_w_line} + {2'b00, bus.mem_r_line}
                   + {2'b00, bus.mem_w_one}  + {2'b00, bus.mem_r_one};
  assign any_req   = (req_count != 3'd0);
  assign multi_req = (req_count > 3'd1);

  // Next-state, access sequencing and read-data capture
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    store_d     = store_q;
    line_read_d = line_read_q;
    rd_pend_d   = 1'b0;
    rd_idx_d    = rd_idx_q;
    perr_d      = perr_q;
    sram_addr   = '0;
    sram_wdata  = '0;
    sram_we     = 1'b0;
    sram_re     = 1'b0;

    // Data of the read issued last cycle is on sram_rdata now
    if (rd_pend_q) begin
      line_read_d[rd_idx_q] = sram_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          addr_d  = bus.mem_addr[SRAM_AW-1:0];
          store_d = bus.line_store;
          idx_d   = '0;
          if (multi_req) perr_d = 1'b1;
          if (bus.mem_w_line)      state_d = S_W_LINE;
          else if (bus.mem_r_line) state_d = S_R_LINE;
          else if (bus.mem_w_one)  state_d = S_W_ONE;
          else                     state_d = S_R_ONE;
        end
      end
      S_W_LINE: begin
        sram_we    = 1'b1;
        sram_addr  = {addr_q[SRAM_AW-1:OFF_W], idx_q[OFF_W-1:0]};
        sram_wdata = store_q[idx_q[OFF_W-1:0]];
        idx_d      = idx_q + 1'b1;
        if (idx_q == IDX_W'(LINE_WORDS - 1)) state_d = S_DONE;
      end
      S_R_LINE: begin
        if (idx_q < IDX_W'(LINE_WORDS)) begin
          sram_re   = 1'b1;
          sram_addr = {addr_q[SRAM_AW-1:OFF_W], idx_q[OFF_W-1:0]};
          rd_pend_d = 1'b1;
          rd_idx_d  = idx_q[OFF_W-1:0];
          idx_d     = idx_q + 1'b1;
        end else begin
          // Drain cycle: the last word is captured here
          state_d = S_DONE;
        end
      end
      S_W_ONE: begin
        sram_we    = 1'b1;
        sram_addr  = addr_q;
        sram_wdata = store_q[0];
        state_d    = S_DONE;
      end
      S_R_ONE: begin
        if (idx_q == '0) begin
          sram_re   = 1'b1;
          sram_addr = addr_q;
          rd_pend_d = 1'b1;
          rd_idx_d  = '0;
          idx_d     = IDX_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = any_req ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!any_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      store_q     <= '0;
      line_read_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      line_read_q <= line_read_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.line_read    = line_read_q;
  assign bus.mem_ready    = (state_q == S_IDLE);
  assign bus.mem_done     = (state_q == S_DONE);
  assign bus.protocol_err = perr_q;

endmodule
`default_nettype wire
